// File: rtl/clk_pulse_stretch_if.sv
// Trigger, per-pulse configuration and status bundle for clk_pulse_stretch.
// The master drives triggers and configuration; the slave reports status.
interface clk_pulse_stretch_if #(
   parameter int CNT_BITS = 16,
   parameter int ACC_BITS = 16
);
   logic                trigger;
   logic                enable;
   logic [CNT_BITS-1:0] delay;
   logic [CNT_BITS-1:0] width;
   logic [CNT_BITS-1:0] holdoff;
   logic                retrigger;
   logic                clear_count;
   logic                q;
   logic                busy;
   logic                missed;
   logic [ACC_BITS-1:0] accepted;

   modport master (
      output trigger, enable, delay, width, holdoff,
      output retrigger, clear_count,
      input  q, busy, missed, accepted
   );

   modport slave (
      input  trigger, enable, delay, width, holdoff,
      input  retrigger, clear_count,
      output q, busy, missed, accepted
   );
endinterface

// File: rtl/clk_pulse_stretch.sv
// Stretches single-cycle triggers into one pulse with programmable
// delay, width and holdoff, plus accepted/missed trigger status.
module clk_pulse_stretch #(
   parameter int CNT_BITS = 16,
   parameter int ACC_BITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   clk_pulse_stretch_if.slave io
);
   typedef enum logic [1:0] {
      IDLE, DELAY, ACTIVE, HOLDOFF
   } state_e;

   localparam logic [CNT_BITS-1:0] ONE = 1;

   state_e              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [CNT_BITS-1:0] width_q, width_d;
   logic [CNT_BITS-1:0] hold_q, hold_d;
   logic                retrig_q, retrig_d;
   logic                rearm_q, rearm_d;
   logic                q_q, q_d;
   logic                missed_q, missed_d;
   logic [ACC_BITS-1:0] acc_q, acc_d;
   logic                acc_inc;
   logic                miss;

   // Counter load for an active phase of max(w,1) cycles.
   function automatic logic [CNT_BITS-1:0] span(
      input logic [CNT_BITS-1:0] w
   );
      return (w == '0) ? '0 : w - ONE;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         width_q  <= '0;
         hold_q   <= '0;
         retrig_q <= 1'b0;
         rearm_q  <= 1'b0;
         q_q      <= 1'b0;
         missed_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         width_q  <= width_d;
         hold_q   <= hold_d;
         retrig_q <= retrig_d;
         rearm_q  <= rearm_d;
         q_q      <= q_d;
         missed_q <= missed_d;
         acc_q    <= acc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      width_d  = width_q;
      hold_d   = hold_q;
      retrig_d = retrig_q;
      rearm_d  = 1'b0;
      acc_inc  = 1'b0;
      miss     = 1'b0;
      if (!io.enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // First idle cycle after a pulse still rejects triggers.
               if (io.trigger && rearm_q) begin
                  miss = 1'b1;
               end else if (io.trigger) begin
                  acc_inc  = 1'b1;
                  width_d  = io.width;
                  hold_d   = io.holdoff;
                  retrig_d = io.retrigger;
                  if (io.delay == '0) begin
                     state_d = ACTIVE;
                     cnt_d   = span(io.width);
                  end else begin
                     state_d = DELAY;
                     cnt_d   = io.delay - ONE;
                  end
               end
            end
            DELAY: begin
               miss = io.trigger;
               if (cnt_q == '0) begin
                  state_d = ACTIVE;
                  cnt_d   = span(width_q);
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            ACTIVE: begin
               if (io.trigger && retrig_q) begin
                  acc_inc = 1'b1;
                  cnt_d   = span(io.width);
               end else begin
                  miss = io.trigger;
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - ONE;
                  end else if (hold_q != '0) begin
                     state_d = HOLDOFF;
                     cnt_d   = hold_q - ONE;
                  end else begin
                     state_d = IDLE;
                     rearm_d = 1'b1;
                  end
               end
            end
            HOLDOFF: begin
               miss = io.trigger;
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  rearm_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      q_d      = (state_d == ACTIVE);
      missed_d = miss & ~io.clear_count;
      acc_d    = acc_q + {{(ACC_BITS-1){1'b0}}, acc_inc};
      if (io.clear_count) begin
         acc_d = '0;
      end
   end

   assign io.q        = q_q;
   assign io.busy     = (state_q != IDLE);
   assign io.missed   = missed_q;
   assign io.accepted = acc_q;
endmodule
